sdram_wr_feeder: RTL and testbench
==================================

Name: sdram_wr_feeder

Overview:
- Upstream feeder for the SDRAM write path. Buffers a continuous 16-bit user data stream in an on-chip FIFO.
- When at least one full burst is buffered, it issues a write request (wr_trig/wr_len/wr_addr) to the SDRAM write engine. It supplies data words on the engine's wr_data_en strobe.
- Keeps a linear SDRAM word address that advances by one burst after each completed burst.

Parameters:
- BURST_LEN, 8, words per write request; driven on wr_len; legal 1..255.
- FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW; depth must be >= 2*BURST_LEN.
- START_ADDR, 21'd0, wr_addr value after reset and after addr_clr.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- srst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  user word present.
- in_data  in  16  user write data.
- in_ready  out  1  FIFO can accept a word this cycle.
- addr_clr  in  1  single-cycle pulse; reload address pointer to START_ADDR.
- wr_trig  out  1  single-cycle write request to the write engine.
- wr_len  out  8  burst length; constant BURST_LEN.
- wr_addr  out  21  SDRAM word address of the current burst ({row,col}; bank fixed downstream).
- wr_data  out  16  FIFO head word (show-ahead).
- wr_data_en  in  1  write engine consumes wr_data this cycle.
- fifo_count  out  FIFO_AW+1  words currently buffered.
- busy  out  1  request issued, burst not yet fully consumed.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: wr_trig=0, busy=0, underflow=0, fifo_count=0, wr_addr=START_ADDR, in_ready=1.
  - FIFO pointers cleared. An in-flight burst is abandoned; no state survives.
- FIFO:
  - Push when in_valid && in_ready. in_ready = (fifo_count != 2^FIFO_AW), combinational from registered count.
  - Pop when wr_data_en && fifo_count != 0.
  - wr_data is the head word, valid whenever fifo_count != 0, and presents the next word in the cycle after a pop.
  - Push and pop in the same cycle: count unchanged, both take effect; legal at full (no pop-then-push bypass needed, in_ready stays 0 at full) and at empty (pop suppressed, push lands).
  - fifo_count is registered; a push in cycle N is reflected in cycle N+1.
  - Read/write pointers wrap modulo 2^FIFO_AW.
- wr_data_en with FIFO empty: no pop, underflow set to 1 and held until reset. The burst counter still increments, so the burst closes on schedule.
- FSM states:
  - S_IDLE: if fifo_count >= BURST_LEN, assert wr_trig for exactly one cycle (registered, i.e. the cycle after the condition is seen), clear burst counter, go S_BUSY. Otherwise stay.
  - S_BUSY: busy=1. Count wr_data_en strobes. On the strobe that makes the count equal BURST_LEN: wr_addr <= wr_addr + BURST_LEN (21-bit, wraps modulo 2^21 silently), go S_DONE.
  - S_DONE: one-cycle gap, busy=0, then S_IDLE. Guarantees at least 2 cycles between consecutive wr_trig pulses.
- Pauses inside a burst are tolerated indefinitely, e.g. an auto-refresh preempting the write engine. No timeout.
- wr_addr and wr_len are stable from the wr_trig cycle through the final wr_data_en of that burst.
- addr_clr:
  - In S_IDLE or S_DONE: wr_addr <= START_ADDR next cycle.
  - In S_BUSY: deferred. The end-of-burst update loads START_ADDR instead of wr_addr + BURST_LEN.
  - Asserted together with the burst-completing strobe: START_ADDR wins.
- wr_trig is never asserted while busy=1.

Test Plan:
- Reset then push 7 words (BURST_LEN=8) -> no wr_trig, fifo_count=7. Push the 8th -> wr_trig high exactly 1 cycle, wr_addr=0, wr_len=8, busy=1.
- Push 0x1000..0x1007 and strobe wr_data_en 8 consecutive cycles -> wr_data sequence 0x1000..0x1007, busy drops, wr_addr=8, fifo_count=0.
- Push 24 words continuously while the engine serves bursts with 3-cycle gaps between strobes -> three wr_trig pulses at addresses 0, 8, 16; data in order; underflow=0.
- Fill FIFO to 512 without strobes -> in_ready=0 at count 512 and further pushes dropped. One pop plus in_valid in the same cycle -> count stays 511 then accepts the next push.
- Preload wr_addr to 21'h1FFFF8 via repeated bursts (or force), complete a burst -> wr_addr wraps to 0. addr_clr mid-burst -> wr_addr=START_ADDR after the final strobe, not before.
- Strobe wr_data_en with FIFO empty -> underflow=1 sticky, fifo_count stays 0. Assert srst_n low mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sdram_wr_feeder.sv
// sdram_wr_feeder: buffers a 16-bit user stream in an on-chip FIFO and hands
// fixed-length bursts to the SDRAM write engine. A request goes out once a full
// burst is buffered. The SDRAM word address advances by one burst each time.
module sdram_wr_feeder #(
    parameter int          BURST_LEN  = 8,
    parameter int          FIFO_AW    = 9,
    parameter logic [20:0] START_ADDR = 21'd0
) (
    input  logic               sclk,
    input  logic               srst_n,
    input  logic               in_valid,
    input  logic [15:0]        in_data,
    output logic               in_ready,
    input  logic               addr_clr,
    output logic               wr_trig,
    output logic [7:0]         wr_len,
    output logic [20:0]        wr_addr,
    output logic [15:0]        wr_data,
    input  logic               wr_data_en,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               busy,
    output logic               underflow
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] BURST_C   = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [8:0]       LAST_C    = 9'(BURST_LEN);
    localparam logic [20:0]      ADDR_STEP = 21'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [15:0]        mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW-1:0] rd_addr_next;
    logic [FIFO_AW:0]   count_reg;
    logic [15:0]        head_reg;
    logic               push;
    logic               pop;

    assign in_ready     = (count_reg != DEPTH_C);
    assign push         = in_valid && in_ready;
    assign pop          = wr_data_en && (count_reg != '0);
    // Address the head register should hold after this edge.
    assign rd_addr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    assign fifo_count = count_reg;
    assign wr_data    = head_reg;
    assign wr_len     = 8'(BURST_LEN);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^FIFO_AW.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // RAM write port plus registered show-ahead read. When the word being
    // written lands at the address about to become the head (empty FIFO, or
    // the last word just popped) the RAM would return stale data, so the
    // incoming word is forwarded straight into the head register.
    always_ff @(posedge sclk) begin
        if (push)
            mem[wr_ptr_reg] <= in_data;
        if (push && (wr_ptr_reg == rd_addr_next))
            head_reg <= in_data;
        else
            head_reg <= mem[rd_addr_next];
    end

    // ------------------------------------------------------------------
    // Burst request FSM
    // ------------------------------------------------------------------
    state_t      state_reg;
    logic [7:0]  burst_cnt_reg;
    logic [8:0]  burst_cnt_inc;
    logic        burst_last;
    logic        clr_pending_reg;
    logic        wr_trig_reg;
    logic        busy_reg;
    logic [20:0] addr_reg;
    logic        underflow_reg;

    assign burst_cnt_inc = {1'b0, burst_cnt_reg} + 9'd1;
    assign burst_last    = (burst_cnt_inc == LAST_C);

    assign wr_trig   = wr_trig_reg;
    assign busy      = busy_reg;
    assign wr_addr   = addr_reg;
    assign underflow = underflow_reg;

    // Request/track/close one burst at a time; an addr_clr seen mid-burst is
    // held until the burst closes so the address stays stable for the engine.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_reg       <= S_IDLE;
            burst_cnt_reg   <= '0;
            clr_pending_reg <= 1'b0;
            wr_trig_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            addr_reg        <= START_ADDR;
        end else begin
            wr_trig_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (addr_clr)
                        addr_reg <= START_ADDR;
                    if (count_reg >= BURST_C) begin
                        wr_trig_reg     <= 1'b1;
                        busy_reg        <= 1'b1;
                        burst_cnt_reg   <= '0;
                        clr_pending_reg <= 1'b0;
                        state_reg       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (wr_data_en) begin
                        burst_cnt_reg <= burst_cnt_inc[7:0];
                        if (burst_last) begin
                            if (addr_clr || clr_pending_reg)
                                addr_reg <= START_ADDR;
                            else
                                addr_reg <= addr_reg + ADDR_STEP;
                            clr_pending_reg <= 1'b0;
                            busy_reg        <= 1'b0;
                            state_reg       <= S_DONE;
                        end else if (addr_clr) begin
                            clr_pending_reg <= 1'b1;
                        end
                    end else if (addr_clr) begin
                        clr_pending_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (addr_clr)
                        addr_reg <= START_ADDR;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky flag for a strobe that arrives with nothing buffered.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n)
            underflow_reg <= 1'b0;
        else if (wr_data_en && (count_reg == '0))
            underflow_reg <= 1'b1;
    end

endmodule

// File: tb/tb_sdram_wr_feeder.sv
// Directed self-checking bench for sdram_wr_feeder. A second instance with a
// start address near the top of the 21-bit space covers address wrap and the
// addr_clr cases.
module tb_sdram_wr_feeder;

    logic        sclk;
    logic        srst_n;

    // Instance 1: defaults (BURST_LEN=8, depth 512, START_ADDR=0)
    logic        in_valid, addr_clr, wr_data_en;
    logic [15:0] in_data;
    logic        in_ready, wr_trig, busy, underflow;
    logic [7:0]  wr_len;
    logic [20:0] wr_addr;
    logic [15:0] wr_data;
    logic [9:0]  fifo_count;

    // Instance 2: START_ADDR=0x1FFFF8, depth 16
    logic        in_valid2, addr_clr2, wr_data_en2;
    logic [15:0] in_data2;
    logic        in_ready2, wr_trig2, busy2, underflow2;
    logic [7:0]  wr_len2;
    logic [20:0] wr_addr2;
    logic [15:0] wr_data2;
    logic [4:0]  fifo_count2;

    int n_checks = 0;
    int n_fail   = 0;
    int trig_cnt = 0;

    sdram_wr_feeder dut (
        .sclk(sclk), .srst_n(srst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .addr_clr(addr_clr), .wr_trig(wr_trig), .wr_len(wr_len),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_data_en(wr_data_en),
        .fifo_count(fifo_count), .busy(busy), .underflow(underflow)
    );

    sdram_wr_feeder #(.BURST_LEN(8), .FIFO_AW(4), .START_ADDR(21'h1FFFF8)) dut2 (
        .sclk(sclk), .srst_n(srst_n),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .addr_clr(addr_clr2), .wr_trig(wr_trig2), .wr_len(wr_len2),
        .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_data_en(wr_data_en2),
        .fifo_count(fifo_count2), .busy(busy2), .underflow(underflow2)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Count request pulses of instance 1, sampled mid-cycle.
    always @(negedge sclk) begin
        if (srst_n && wr_trig)
            trig_cnt <= trig_cnt + 1;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic apply_reset();
        srst_n = 1'b0;
        in_valid = 0; in_data = 0; addr_clr = 0; wr_data_en = 0;
        in_valid2 = 0; in_data2 = 0; addr_clr2 = 0; wr_data_en2 = 0;
        repeat (2) step();
        srst_n = 1'b1;
        step();
    endtask

    task automatic push_words(input int sel, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin in_valid = 1; in_data = base + 16'(i); end
            else          begin in_valid2 = 1; in_data2 = base + 16'(i); end
            step();
        end
        in_valid = 0; in_valid2 = 0;
    endtask

    // Consecutive strobes; returns how many heads differed from base+i.
    task automatic strobe(input int sel, input logic [15:0] base, input int n, output int errs);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin
                if (wr_data !== base + 16'(i)) errs++;
                wr_data_en = 1;
            end else begin
                if (wr_data2 !== base + 16'(i)) errs++;
                wr_data_en2 = 1;
            end
            step();
        end
        wr_data_en = 0; wr_data_en2 = 0;
    endtask

    task automatic wait_trig(input string tag, input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? wr_trig : wr_trig2) == 1'b0 && n < 60) begin
            step();
            n++;
        end
        check(tag, 32'(n < 60), 32'd1);
    endtask

    initial begin
        int errs;
        int t0;

        // ---------------- reset values ----------------
        srst_n = 1'b0;
        in_valid = 0; in_data = 0; addr_clr = 0; wr_data_en = 0;
        in_valid2 = 0; in_data2 = 0; addr_clr2 = 0; wr_data_en2 = 0;
        repeat (2) step();
        check("rst_trig", 32'(wr_trig), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_addr", 32'(wr_addr), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_addr2", 32'(wr_addr2), 32'h1FFFF8);
        srst_n = 1'b1;
        step();

        // ---------------- threshold: 7 words then the 8th ----------------
        t0 = trig_cnt;
        push_words(0, 16'h1000, 7);
        step();
        check("cnt7", 32'(fifo_count), 7);
        check("no_trig_at_7", 32'(trig_cnt - t0), 0);
        in_valid = 1; in_data = 16'h1007;
        step();
        in_valid = 0;
        check("cnt8", 32'(fifo_count), 8);
        step();
        check("trig_high", 32'(wr_trig), 1);
        check("trig_addr", 32'(wr_addr), 0);
        check("trig_len", 32'(wr_len), 8);
        check("trig_busy", 32'(busy), 1);
        step();
        check("trig_one_cycle", 32'(wr_trig), 0);

        // ---------------- 8 back-to-back strobes ----------------
        strobe(0, 16'h1000, 8, errs);
        check("burst_data", 32'(errs), 0);
        check("burst_busy_low", 32'(busy), 0);
        check("burst_addr_next", 32'(wr_addr), 8);
        check("burst_count0", 32'(fifo_count), 0);
        step();
        addr_clr = 1;
        step();
        addr_clr = 0;
        check("idle_addr_clr", 32'(wr_addr), 0);

        // ---------------- 24 words, engine with 3-cycle gaps ----------------
        apply_reset();
        t0 = trig_cnt;
        fork
            begin
                push_words(0, 16'h2000, 24);
            end
            begin
                for (int b = 0; b < 3; b++) begin
                    wait_trig($sformatf("gap_trig%0d", b), 0);
                    check($sformatf("gap_addr%0d", b), 32'(wr_addr), 32'(b * 8));
                    errs = 0;
                    for (int k = 0; k < 8; k++) begin
                        repeat (3) step();
                        if (wr_data !== 16'h2000 + 16'(b * 8 + k)) errs++;
                        wr_data_en = 1;
                        step();
                        wr_data_en = 0;
                    end
                    check($sformatf("gap_data%0d", b), 32'(errs), 0);
                end
            end
        join
        repeat (3) step();
        check("gap_trig_total", 32'(trig_cnt - t0), 3);
        check("gap_underflow", 32'(underflow), 0);
        check("gap_count0", 32'(fifo_count), 0);

        // ---------------- full FIFO ----------------
        apply_reset();
        push_words(0, 16'h3000, 512);
        check("full_count", 32'(fifo_count), 512);
        check("full_in_ready", 32'(in_ready), 0);
        in_valid = 1; in_data = 16'hDEAD;
        repeat (3) step();
        check("full_drop", 32'(fifo_count), 512);
        check("full_head", 32'(wr_data), 16'h3000);
        in_data = 16'hBEEF; wr_data_en = 1;
        step();
        wr_data_en = 0;
        check("full_pop_push_cnt", 32'(fifo_count), 511);
        check("full_pop_head", 32'(wr_data), 16'h3001);
        check("full_ready_again", 32'(in_ready), 1);
        in_data = 16'h4000;
        step();
        in_valid = 0;
        check("full_refill", 32'(fifo_count), 512);
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            if (wr_data !== ((i < 511) ? 16'h3001 + 16'(i) : 16'h4000)) errs++;
            wr_data_en = 1;
            step();
        end
        wr_data_en = 0;
        check("full_drain_data", 32'(errs), 0);
        check("full_drain_cnt", 32'(fifo_count), 0);
        check("full_no_underflow", 32'(underflow), 0);

        // ---------------- address wrap and addr_clr (instance 2) ----------------
        apply_reset();
        push_words(1, 16'h7000, 8);
        wait_trig("wrap_trig", 1);
        check("wrap_start_addr", 32'(wr_addr2), 32'h1FFFF8);
        check("wrap_len", 32'(wr_len2), 8);
        strobe(1, 16'h7000, 8, errs);
        check("wrap_data", 32'(errs), 0);
        check("wrap_addr0", 32'(wr_addr2), 0);
        push_words(1, 16'h7100, 8);
        wait_trig("clr_trig", 1);
        check("clr_addr_before", 32'(wr_addr2), 0);
        strobe(1, 16'h7100, 4, errs);
        addr_clr2 = 1;
        step();
        addr_clr2 = 0;
        check("clr_deferred", 32'(wr_addr2), 0);
        strobe(1, 16'h7104, 3, errs);
        check("clr_still_deferred", 32'(wr_addr2), 0);
        strobe(1, 16'h7107, 1, t0);
        check("clr_data", 32'(errs + t0), 0);
        check("clr_applied", 32'(wr_addr2), 32'h1FFFF8);
        push_words(1, 16'h7200, 8);
        wait_trig("clr_last_trig", 1);
        strobe(1, 16'h7200, 7, errs);
        wr_data_en2 = 1; addr_clr2 = 1;
        step();
        wr_data_en2 = 0; addr_clr2 = 0;
        check("clr_with_last", 32'(wr_addr2), 32'h1FFFF8);
        check("clr_busy2_low", 32'(busy2), 0);

        // ---------------- underflow and async reset mid-burst ----------------
        apply_reset();
        wr_data_en = 1;
        step();
        wr_data_en = 0;
        check("uf_set", 32'(underflow), 1);
        check("uf_count0", 32'(fifo_count), 0);
        repeat (2) step();
        check("uf_sticky", 32'(underflow), 1);
        in_valid = 1; in_data = 16'h5555; wr_data_en = 1;
        step();
        in_valid = 0; wr_data_en = 0;
        check("empty_push_pop_cnt", 32'(fifo_count), 1);
        check("empty_push_pop_head", 32'(wr_data), 16'h5555);
        push_words(0, 16'h6000, 7);
        wait_trig("ar_trig", 0);
        strobe(0, 16'h5555, 1, errs);
        strobe(0, 16'h6000, 2, t0);
        check("ar_data", 32'(errs + t0), 0);
        check("ar_busy_before", 32'(busy), 1);
        #3;
        srst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_trig_low", 32'(wr_trig), 0);
        check("ar_underflow", 32'(underflow), 0);
        check("ar_count", 32'(fifo_count), 0);
        check("ar_addr", 32'(wr_addr), 0);
        check("ar_in_ready", 32'(in_ready), 1);
        step();
        srst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
